ssio_ddr_out_gated: RTL and testbench
=====================================

// Module: ssio_ddr_out_gated
// PURPOSE
//  Source-synchronous DDR transmitter with a forwarded clock that runs only around bursts.
//  Accepts d1/d2 beat pairs over a valid/ready handshake and drives them through DDR output registers.
//  Runs the forwarded clock LEAD_CYCLES before the first beat and TRAIL_CYCLES after the last beat.
//  Parks clock and data at a fixed idle level otherwise.
//  Sits between MAC-side TX logic and the pins (RGMII-like / custom SSIO links).
// PARAMETERS
//  TARGET        "GENERIC"  "SIM"/"GENERIC"/"XILINX"/"ALTERA", passed to oddr
//  IODDR_STYLE   "IODDR2"   "IODDR"/"IODDR2", passed to oddr
//  WIDTH         4          data lanes
//  LEAD_CYCLES   2          clock-running idle cycles before first beat (0 legal)
//  TRAIL_CYCLES  2          clock-running idle cycles after last beat (0 legal)
//  IDLE_VALUE    '0         WIDTH-bit value driven on both edges when no beat is sent
// PORTS
//  clk         in   1      single clock; data and forwarded clock both launched from it
//  rst_n       in   1      asynchronous active-low reset
//  enable      in   1      permits IDLE->LEAD; does not abort a run in progress
//  s_d1        in   WIDTH  rising-edge data of beat
//  s_d2        in   WIDTH  falling-edge data of beat
//  s_valid     in   1      beat valid
//  s_ready     out  1      beat accepted when s_valid && s_ready
//  busy        out  1      state != IDLE (registered)
//  output_clk  out  1      forwarded DDR clock (oddr, d1=clk_en_q, d2=0)
//  output_q    out  WIDTH  DDR data pins (oddr, d1=d1_q, d2=d2_q)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, cnt=0, clk_en_q=0, d1_q=d2_q=IDLE_VALUE, s_ready=0, busy=0.
//   - Forwarded clock held low.
//  FSM, one transition per clk:
//   IDLE : clk_en=0. If enable && s_valid: LEAD_CYCLES>0 -> LEAD (cnt=LEAD_CYCLES-1), else -> ACTIVE.
//   LEAD : clk_en=1, data=IDLE_VALUE. cnt==0 -> ACTIVE, else cnt--.
//   ACTIVE : clk_en=1; s_ready=1 (combinational from state only, never from s_valid).
//     - s_valid: register s_d1/s_d2, stay in ACTIVE.
//     - !s_valid: drive IDLE_VALUE this cycle.
//       TRAIL_CYCLES>0 -> TRAIL (cnt=TRAIL_CYCLES-1), else -> IDLE.
//   TRAIL : clk_en=1, data=IDLE_VALUE, s_ready=0.
//     - s_valid -> ACTIVE next cycle; no new lead; clock never stops.
//     - Else cnt==0 -> IDLE, else cnt--.
//  Latency:
//   - Beat accepted at edge N appears on d1_q/d2_q at N+1.
//   - Reaches pins after oddr latency (1 clk GENERIC/SIM).
//   - clk_en_q is pipelined identically, so forwarded clock pulses align 1:1 with data beats.
//  Counter: width $clog2(max(LEAD_CYCLES,TRAIL_CYCLES)+1), min 1; never wraps (loaded, counts to 0).
//  Boundary cases:
//   - enable drop mid-run: run completes normally; no new run starts while enable=0.
//   - s_valid dropping in ACTIVE: always ends the burst (gap = TRAIL), no zero-length bubbles on pins.
//   - rst_n asserted mid-burst: immediate IDLE values on registers; clock stops at once (truncation allowed).
//   - LEAD_CYCLES=0 and TRAIL_CYCLES=0: clock runs exactly during beats and the one idle cycle ending ACTIVE.
// STRUCTURE
//  ssio_pkg:
//   - typedef enum logic [1:0] {SSIO_IDLE, SSIO_LEAD, SSIO_ACTIVE, SSIO_TRAIL} ssio_out_state_t.
//   - Helper function for counter width.
//  Sub-modules: two existing oddr instances (clock WIDTH=1, data WIDTH=WIDTH); FSM and registers inline.
// TESTING (WIDTH=4, LEAD=2, TRAIL=2, IDLE_VALUE=0, GENERIC)
//  1 Reset: rst_n=0 with s_valid=1
//    -> output_clk=0, output_q=0, s_ready=0, busy=0 throughout; no clock pulse after release until enable.
//  2 Single burst: enable=1, 3 beats (d1/d2 = 1/2, 3/4, 5/6)
//    -> 2 idle clock pulses, then pins 1,2,3,4,5,6 on successive edges, then 3 idle pulses
//       (end cycle + TRAIL); then clock stops.
//  3 Re-entry in TRAIL: new beat A/B one cycle into TRAIL
//    -> no clock gap, no new lead; A/B follows 2 idle pulses.
//  4 Backpressure: s_valid held before LEAD done
//    -> s_ready=0 for exactly 1+LEAD cycles after s_valid; first beat never lost or duplicated.
//  5 enable=0 mid-ACTIVE
//    -> remaining beats sent and trail completes; s_valid afterwards keeps IDLE, clock stopped.
//  6 rst_n pulsed mid-burst
//    -> same-cycle output_clk low and d*_q=0, state IDLE; clean new burst after release.

Source files
------------

// File: rtl/ssio_pkg.sv
// rtl/ssio_pkg.sv - shared types and helpers for the gated-clock SSIO DDR transmitter
package ssio_pkg;

    typedef enum logic [1:0] {
        SSIO_IDLE,
        SSIO_LEAD,
        SSIO_ACTIVE,
        SSIO_TRAIL
    } ssio_out_state_t;

    // Counter must hold the larger of the two preload values; never narrower than 1 bit.
    function automatic int ssio_cnt_width(input int lead_cycles, input int trail_cycles);
        int max_cycles;
        int w;
        max_cycles = (lead_cycles > trail_cycles) ? lead_cycles : trail_cycles;
        w = $clog2(max_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/oddr.sv
// rtl/oddr.sv - DDR output register: d1 driven while clk is high, d2 while clk is low
module oddr #(
    parameter TARGET      = "GENERIC",
    parameter IODDR_STYLE = "IODDR2",
    parameter int WIDTH   = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_pos;
    logic [WIDTH-1:0] q_neg;

    always_ff @(posedge clk) begin
        q_pos <= d1;
    end

    // ODDR2-style primitives capture d2 on the falling edge; the others hold it from the rising edge.
    if (IODDR_STYLE == "IODDR2" && TARGET != "GENERIC" && TARGET != "SIM") begin : g_fall_capture
        always_ff @(negedge clk) begin
            q_neg <= d2;
        end
    end else begin : g_same_edge
        logic [WIDTH-1:0] d2_hold;

        always_ff @(posedge clk) begin
            d2_hold <= d2;
        end

        always_ff @(negedge clk) begin
            q_neg <= d2_hold;
        end
    end

    assign q = clk ? q_pos : q_neg;

endmodule

// File: rtl/ssio_ddr_out_gated.sv
// rtl/ssio_ddr_out_gated.sv - source-synchronous DDR transmitter with burst-gated forwarded clock
module ssio_ddr_out_gated
    import ssio_pkg::*;
#(
    parameter TARGET                 = "GENERIC",
    parameter IODDR_STYLE            = "IODDR2",
    parameter int WIDTH              = 4,
    parameter int LEAD_CYCLES        = 2,
    parameter int TRAIL_CYCLES       = 2,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] s_d1,
    input  logic [WIDTH-1:0] s_d2,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             busy,
    output logic             output_clk,
    output logic [WIDTH-1:0] output_q
);

    localparam int CW = ssio_cnt_width(LEAD_CYCLES, TRAIL_CYCLES);
    localparam logic [CW-1:0] LEAD_LOAD  = (LEAD_CYCLES  > 0) ? CW'(LEAD_CYCLES  - 1) : '0;
    localparam logic [CW-1:0] TRAIL_LOAD = (TRAIL_CYCLES > 0) ? CW'(TRAIL_CYCLES - 1) : '0;

    ssio_out_state_t  state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             clk_en, clk_en_q;
    logic [WIDTH-1:0] d1_next, d2_next;
    logic [WIDTH-1:0] d1_q, d2_q;
    logic             clk_pin;
    logic [WIDTH-1:0] q_pin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SSIO_IDLE;
            cnt      <= '0;
            clk_en_q <= 1'b0;
            d1_q     <= IDLE_VALUE;
            d2_q     <= IDLE_VALUE;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            clk_en_q <= clk_en;
            d1_q     <= d1_next;
            d2_q     <= d2_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            SSIO_IDLE: begin
                if (enable && s_valid) begin
                    if (LEAD_CYCLES > 0) begin
                        state_next = SSIO_LEAD;
                        cnt_next   = LEAD_LOAD;
                    end else begin
                        state_next = SSIO_ACTIVE;
                    end
                end
            end
            SSIO_LEAD: begin
                if (cnt == '0) begin
                    state_next = SSIO_ACTIVE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            SSIO_ACTIVE: begin
                // Any gap ends the burst so the pins never show a lone idle bubble mid-burst.
                if (!s_valid) begin
                    if (TRAIL_CYCLES > 0) begin
                        state_next = SSIO_TRAIL;
                        cnt_next   = TRAIL_LOAD;
                    end else begin
                        state_next = SSIO_IDLE;
                    end
                end
            end
            SSIO_TRAIL: begin
                if (s_valid) begin
                    state_next = SSIO_ACTIVE;
                end else if (cnt == '0) begin
                    state_next = SSIO_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = SSIO_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        clk_en  = (state != SSIO_IDLE);
        s_ready = (state == SSIO_ACTIVE);
        d1_next = IDLE_VALUE;
        d2_next = IDLE_VALUE;
        if (s_ready && s_valid) begin
            d1_next = s_d1;
            d2_next = s_d2;
        end
    end

    assign busy = (state != SSIO_IDLE);

    oddr #(
        .TARGET      (TARGET),
        .IODDR_STYLE (IODDR_STYLE),
        .WIDTH       (1)
    ) u_clk_oddr (
        .clk (clk),
        .d1  (clk_en_q),
        .d2  (1'b0),
        .q   (clk_pin)
    );

    oddr #(
        .TARGET      (TARGET),
        .IODDR_STYLE (IODDR_STYLE),
        .WIDTH       (WIDTH)
    ) u_data_oddr (
        .clk (clk),
        .d1  (d1_q),
        .d2  (d2_q),
        .q   (q_pin)
    );

    // The oddr stages have no reset, so reset parks the pins directly and stops the clock at once.
    assign output_clk = rst_n & clk_pin;
    assign output_q   = rst_n ? q_pin : IDLE_VALUE;

endmodule

// File: tb/tb_ssio_ddr_out_gated.sv
// tb/tb_ssio_ddr_out_gated.sv - scoreboard bench for the gated-clock SSIO DDR transmitter
module tb_ssio_ddr_out_gated;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] s_d1;
    logic [3:0] s_d2;
    logic       s_valid;
    logic       s_ready;
    logic       busy;
    logic       output_clk;
    logic [3:0] output_q;

    int n_checks;
    int n_fail;
    int stall_cnt;

    logic [7:0]  sb[$];
    logic        rec_on;
    logic [63:0] pat;
    int          pat_len;
    int          zero_run;

    ssio_ddr_out_gated #(
        .TARGET       ("GENERIC"),
        .IODDR_STYLE  ("IODDR2"),
        .WIDTH        (4),
        .LEAD_CYCLES  (2),
        .TRAIL_CYCLES (2),
        .IDLE_VALUE   (4'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_d1       (s_d1),
        .s_d2       (s_d2),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .busy       (busy),
        .output_clk (output_clk),
        .output_q   (output_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin pattern: 'I' idle clock pulse, 'B' data beat, '.' no pulse; 2 bits per symbol.
    function automatic logic [63:0] enc(input string s);
        logic [63:0] v;
        byte c;
        v = '0;
        for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            v = (v << 2) | ((c == "B") ? 64'd2 : (c == "I") ? 64'd1 : 64'd0);
        end
        return v;
    endfunction

    task automatic clear_pat();
        pat      = '0;
        pat_len  = 0;
        zero_run = 0;
    endtask

    // Pin monitor: samples each half of every cycle and pops the scoreboard on data beats.
    initial begin
        logic       c_hi, c_lo;
        logic [3:0] q_hi, q_lo;
        logic [7:0] exp_beat;
        int         kind;
        forever begin
            @(posedge clk);
            #2;
            c_hi = output_clk;
            q_hi = output_q;
            @(negedge clk);
            #2;
            c_lo = output_clk;
            q_lo = output_q;
            if (rec_on) begin
                check_eq("clk_low_half", {63'd0, c_lo}, 64'd0);
                if (!c_hi) begin
                    kind = 0;
                    check_eq("parked_q", {56'd0, q_hi, q_lo}, 64'd0);
                end else if (q_hi != 4'h0 || q_lo != 4'h0) begin
                    kind = 2;
                    if (sb.size() == 0) begin
                        check_eq("unexpected_beat", {56'd0, q_hi, q_lo}, 64'd0);
                    end else begin
                        exp_beat = sb.pop_front();
                        check_eq("beat", {56'd0, q_hi, q_lo}, {56'd0, exp_beat});
                    end
                end else begin
                    kind = 1;
                end
                if (kind == 0) begin
                    if (pat_len > 0) zero_run++;
                end else begin
                    for (int i = 0; i < zero_run; i++) pat = pat << 2;
                    pat_len  = pat_len + zero_run + 1;
                    zero_run = 0;
                    pat      = (pat << 2) | 64'(kind);
                end
            end
        end
    end

    task automatic send_beat(input logic [3:0] a, input logic [3:0] b);
        logic rdy;
        logic acc;
        s_d1    = a;
        s_d2    = b;
        s_valid = 1'b1;
        acc     = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1'b1;
            else     stall_cnt++;
        end
        if (acc) sb.push_back({a, b});
        else     check_eq("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic end_burst(input string tag, input string exp_pat);
        s_valid = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_busy_drop"}, {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_pattern"}, pat, enc(exp_pat));
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        stall_cnt = 0;
        rec_on    = 1'b0;
        clear_pat();
        rst_n   = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b1;
        s_d1    = 4'hF;
        s_d2    = 4'hF;

        // Reset held with s_valid asserted
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check_eq("rst_clk", {63'd0, output_clk}, 64'd0);
            check_eq("rst_q", {60'd0, output_q}, 64'd0);
            check_eq("rst_ready", {63'd0, s_ready}, 64'd0);
            check_eq("rst_busy", {63'd0, busy}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rec_on = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("post_rst_no_pulse", pat, 64'd0);
        check_eq("post_rst_busy", {63'd0, busy}, 64'd0);

        // Single burst; first beat also measures lead backpressure
        clear_pat();
        stall_cnt = 0;
        enable    = 1'b1;
        send_beat(4'h1, 4'h2);
        check_eq("lead_stall", 64'(stall_cnt), 64'd3);
        send_beat(4'h3, 4'h4);
        send_beat(4'h5, 4'h6);
        end_burst("single", "IIBBBIII");

        // Re-entry one cycle into TRAIL
        clear_pat();
        send_beat(4'h7, 4'h8);
        send_beat(4'h9, 4'h1);
        send_beat(4'h2, 4'h3);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        stall_cnt = 0;
        send_beat(4'hA, 4'hB);
        check_eq("reentry_stall", 64'(stall_cnt), 64'd1);
        end_burst("reentry", "IIBBBIIBIII");

        // enable dropped mid-ACTIVE
        clear_pat();
        send_beat(4'hC, 4'hD);
        send_beat(4'hE, 4'hF);
        enable = 1'b0;
        send_beat(4'h1, 4'h3);
        send_beat(4'h5, 4'h7);
        end_burst("en_drop", "IIBBBBIII");
        clear_pat();
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("dis_ready", {63'd0, s_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("dis_no_pulse", pat, 64'd0);
        check_eq("dis_busy", {63'd0, busy}, 64'd0);

        // Reset pulsed mid-burst, then a clean burst
        clear_pat();
        enable = 1'b1;
        send_beat(4'h2, 4'h4);
        send_beat(4'h6, 4'h8);
        #2;
        rec_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_eq("midrst_clk", {63'd0, output_clk}, 64'd0);
        check_eq("midrst_q", {60'd0, output_q}, 64'd0);
        check_eq("midrst_busy", {63'd0, busy}, 64'd0);
        check_eq("midrst_ready", {63'd0, s_ready}, 64'd0);
        sb.delete();
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_pat();
        rec_on = 1'b1;
        send_beat(4'h9, 4'hA);
        send_beat(4'hB, 4'hC);
        end_burst("after_rst", "IIBBIII");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
